pipelined_reduction_tree: RTL and testbench

Parametrised, pipelined adder tree that sums NUM_ADDENDS operands of NBIT each into one full-precision result.
- Supports any addend count, signed or unsigned operands, configurable register spacing, a valid/ready stream handshake and a sideband tag carried alongside the sum.
- Serves as the accumulation backend for convolution windows (Gaussian/Sobel) in the edge pipeline, where kernel sizes give non-power-of-two addend counts.

---
 rtl/reduction_pkg.sv | 17 +
 rtl/pipelined_reduction_tree_if.sv | 24 ++
 rtl/reduction_level.sv | 16 +
 rtl/pipelined_reduction_tree.sv | 63 ++++++
 tb/tb_pipelined_reduction_tree.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/reduction_pkg.sv
// reduction_pkg: sizing helpers shared by the reduction tree, its levels and its interface
package reduction_pkg;
  function automatic int tree_levels(input int n);
    return $clog2(n);
  endfunction
  function automatic int level_count(input int n, input int k);
    int r = n;
    for (int i = 0; i < k; i++) r = (r + 1) / 2;
    return r;
  endfunction
  function automatic int num_stages(input int levels, input int reg_every);
    return levels == 0 ? 1 : (levels + reg_every - 1) / reg_every;
  endfunction
  function automatic int result_width(input int nbit, input int n);
    return nbit + $clog2(n);
  endfunction
endpackage

// File: rtl/pipelined_reduction_tree_if.sv
// pipelined_reduction_tree_if: operand/tag input stream and sum/tag output stream of the reduction tree
interface pipelined_reduction_tree_if import reduction_pkg::*; #(
  parameter int NBIT = 8,
  parameter int NUM_ADDENDS = 9,
  parameter int TAG_W = 1
);
  localparam int RW = result_width(NBIT, NUM_ADDENDS);
  logic in_valid;
  logic in_ready;
  logic [NBIT-1:0] data_in [NUM_ADDENDS];
  logic [TAG_W-1:0] tag_in;
  logic out_valid;
  logic out_ready;
  logic [RW-1:0] result;
  logic [TAG_W-1:0] tag_out;
  modport slave (
    input in_valid, data_in, tag_in, out_ready,
    output in_ready, out_valid, result, tag_out
  );
  modport master (
    output in_valid, data_in, tag_in, out_ready,
    input in_ready, out_valid, result, tag_out
  );
endinterface

// File: rtl/reduction_level.sv
// reduction_level: one combinational adder level, pairing neighbours and passing an odd last element through
module reduction_level #(
  parameter int IN_COUNT = 2,
  parameter int W = 8,
  parameter int SIGNED = 0
) (
  input  logic [W-1:0] a [IN_COUNT],
  output logic [W-1:0] y [(IN_COUNT + 1) / 2]
);
  for (genvar i = 0; i < IN_COUNT / 2; i++) begin : g_pair
    assign y[i] = SIGNED != 0 ? W'($signed(a[2*i]) + $signed(a[2*i+1])) : a[2*i] + a[2*i+1];
  end
  if (IN_COUNT % 2 != 0) begin : g_odd
    assign y[IN_COUNT / 2] = a[IN_COUNT - 1];
  end
endmodule

// File: rtl/pipelined_reduction_tree.sv
// pipelined_reduction_tree: pipelined adder tree summing NUM_ADDENDS operands at full precision
module pipelined_reduction_tree import reduction_pkg::*; #(
  parameter int NBIT = 8,
  parameter int NUM_ADDENDS = 9,
  parameter int SIGNED = 0,
  parameter int REG_EVERY = 1,
  parameter int TAG_W = 1
) (
  input logic clk,
  input logic rst,
  pipelined_reduction_tree_if.slave bus
);
  localparam int LEVELS = tree_levels(NUM_ADDENDS);
  localparam int RW = result_width(NBIT, NUM_ADDENDS);
  logic en;
  assign en = bus.out_ready || !bus.out_valid;
  assign bus.in_ready = en;
  for (genvar k = 0; k <= LEVELS; k++) begin : g_l
    localparam int N = level_count(NUM_ADDENDS, k);
    logic [RW-1:0] sum [N];
    logic [RW-1:0] q [N];
    logic sum_v, q_v;
    logic [TAG_W-1:0] sum_t, q_t;
    if (k == 0) begin : g_src
      for (genvar i = 0; i < N; i++) begin : g_x
        assign sum[i] = SIGNED != 0 ? RW'($signed(bus.data_in[i])) : RW'(bus.data_in[i]);
      end
      assign sum_v = bus.in_valid;
      assign sum_t = bus.tag_in;
    end else begin : g_add
      reduction_level #(
        .IN_COUNT(level_count(NUM_ADDENDS, k - 1)),
        .W(RW),
        .SIGNED(SIGNED)
      ) u_level (
        .a(g_l[k-1].q),
        .y(sum)
      );
      assign sum_v = g_l[k-1].q_v;
      assign sum_t = g_l[k-1].q_t;
    end
    if (k == LEVELS || (k > 0 && k % REG_EVERY == 0)) begin : g_reg
      // stage register: clears on reset, shifts when the pipe moves, holds on stall
      always_ff @(posedge clk)
        if (rst) begin
          q <= '{default: '0};
          q_v <= 1'b0;
          q_t <= '0;
        end else if (en) begin
          q <= sum;
          q_v <= sum_v;
          q_t <= sum_t;
        end
    end else begin : g_thru
      assign q = sum;
      assign q_v = sum_v;
      assign q_t = sum_t;
    end
  end
  assign bus.out_valid = g_l[LEVELS].q_v;
  assign bus.result = g_l[LEVELS].q[0];
  assign bus.tag_out = g_l[LEVELS].q_t;
endmodule

// File: tb/tb_pipelined_reduction_tree.sv
// tb_pipelined_reduction_tree: directed vectors and scoreboarded streams over four tree configurations
module tb_pipelined_reduction_tree;
  typedef struct {
    int s;
    int d [9];
    int t;
    int e;
  } vec_t;
  int na [4] = '{8, 9, 5, 1};
  int stg [4] = '{3, 4, 2, 1};
  int tmask [4] = '{7, 15, 255, 255};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv [4];
  logic ordy [4];
  logic [7:0] din [4][9];
  logic [7:0] tin [4];
  logic [31:0] ov [4];
  logic [31:0] ir [4];
  logic signed [31:0] res [4];
  logic [31:0] tg [4];
  int nvec = 0;
  int nerr = 0;
  int pops, first_pop, last_pop;
  vec_t vt [13];

  always #5 clk = ~clk;

  pipelined_reduction_tree_if #(.NBIT(8), .NUM_ADDENDS(8), .TAG_W(3)) ia ();
  pipelined_reduction_tree_if #(.NBIT(8), .NUM_ADDENDS(9), .TAG_W(4)) ib ();
  pipelined_reduction_tree_if #(.NBIT(8), .NUM_ADDENDS(5), .TAG_W(8)) ic ();
  pipelined_reduction_tree_if #(.NBIT(8), .NUM_ADDENDS(1), .TAG_W(8)) id ();

  pipelined_reduction_tree #(.NBIT(8), .NUM_ADDENDS(8), .SIGNED(0), .REG_EVERY(1), .TAG_W(3))
    u_a (.clk(clk), .rst(rst), .bus(ia));
  pipelined_reduction_tree #(.NBIT(8), .NUM_ADDENDS(9), .SIGNED(1), .REG_EVERY(1), .TAG_W(4))
    u_b (.clk(clk), .rst(rst), .bus(ib));
  pipelined_reduction_tree #(.NBIT(8), .NUM_ADDENDS(5), .SIGNED(0), .REG_EVERY(2), .TAG_W(8))
    u_c (.clk(clk), .rst(rst), .bus(ic));
  pipelined_reduction_tree #(.NBIT(8), .NUM_ADDENDS(1), .SIGNED(0), .REG_EVERY(1), .TAG_W(8))
    u_d (.clk(clk), .rst(rst), .bus(id));

  always_comb begin
    ia.in_valid = iv[0];
    ib.in_valid = iv[1];
    ic.in_valid = iv[2];
    id.in_valid = iv[3];
    ia.out_ready = ordy[0];
    ib.out_ready = ordy[1];
    ic.out_ready = ordy[2];
    id.out_ready = ordy[3];
    ia.tag_in = tin[0][2:0];
    ib.tag_in = tin[1][3:0];
    ic.tag_in = tin[2];
    id.tag_in = tin[3];
    for (int i = 0; i < 8; i++) ia.data_in[i] = din[0][i];
    for (int i = 0; i < 9; i++) ib.data_in[i] = din[1][i];
    for (int i = 0; i < 5; i++) ic.data_in[i] = din[2][i];
    id.data_in[0] = din[3][0];
  end

  always_comb begin
    ov[0] = 32'(ia.out_valid);
    ov[1] = 32'(ib.out_valid);
    ov[2] = 32'(ic.out_valid);
    ov[3] = 32'(id.out_valid);
    ir[0] = 32'(ia.in_ready);
    ir[1] = 32'(ib.in_ready);
    ir[2] = 32'(ic.in_ready);
    ir[3] = 32'(id.in_ready);
    res[0] = 32'(ia.result);
    res[1] = 32'($signed(ib.result));
    res[2] = 32'(ic.result);
    res[3] = 32'(id.result);
    tg[0] = 32'(ia.tag_out);
    tg[1] = 32'(ib.tag_out);
    tg[2] = 32'(ic.tag_out);
    tg[3] = 32'(id.tag_out);
  end

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", n, $signed(a), a, $signed(e), e);
    end
  endtask

  function automatic logic [31:0] model(input int s);
    int acc = 0;
    for (int i = 0; i < na[s]; i++)
      acc += (s == 1 && din[s][i][7]) ? int'(din[s][i]) - 256 : int'(din[s][i]);
    return acc;
  endfunction

  task automatic apply(input vec_t v);
    int s = v.s;
    int lat;
    @(negedge clk);
    for (int i = 0; i < 9; i++) din[s][i] = 8'(v.d[i]);
    tin[s] = 8'(v.t);
    iv[s] = 1'b1;
    #1 check("vec_in_ready", ir[s], 1);
    @(negedge clk);
    iv[s] = 1'b0;
    lat = 1;
    while (ov[s] == 0 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("vec_latency", lat, stg[s]);
    check("vec_result", res[s], v.e);
    check("vec_tag", tg[s], v.t);
  endtask

  task automatic run(input int s, input int nb, input int pv, input int pr, input int st0, input int stn);
    logic [31:0] qr [$];
    logic [31:0] qt [$];
    logic [31:0] pres, ptg, er, et;
    int sent = 0;
    int cyc = 0;
    logic pending = 1'b0;
    logic stalled = 1'b0;
    pops = 0;
    while ((sent < nb || qr.size() > 0) && cyc < 40 * nb + 100) begin
      @(negedge clk);
      if (stalled) begin
        check("hold_valid", ov[s], 1);
        check("hold_result", res[s], pres);
        check("hold_tag", tg[s], ptg);
      end
      if (!pending) begin
        iv[s] = sent < nb && $urandom_range(99) < pv;
        for (int i = 0; i < 9; i++) din[s][i] = 8'($urandom);
        tin[s] = 8'($urandom);
      end
      ordy[s] = (cyc >= st0 && cyc < st0 + stn) ? 1'b0 : $urandom_range(99) < pr;
      #1;
      if (ov[s] != 0 && !ordy[s]) check("stall_in_ready", ir[s], 0);
      if (ov[s] != 0 && ordy[s]) begin
        if (qr.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL extra_beat: got output %0d with no beat outstanding, expected none", res[s]);
        end else begin
          er = qr.pop_front();
          et = qt.pop_front();
          check("sb_result", res[s], er);
          check("sb_tag", tg[s], et);
          if (pops == 0) first_pop = cyc;
          last_pop = cyc;
          pops++;
        end
      end
      pending = iv[s] && ir[s] == 0;
      if (iv[s] && ir[s] != 0) begin
        qr.push_back(model(s));
        qt.push_back(32'(tin[s]) & 32'(tmask[s]));
        sent++;
      end
      stalled = ov[s] != 0 && !ordy[s];
      pres = res[s];
      ptg = tg[s];
      cyc++;
    end
    iv[s] = 1'b0;
    ordy[s] = 1'b1;
    check("sb_drained", qr.size(), 0);
    check("sb_all_sent", sent, nb);
  endtask

  initial begin
    vt = '{
      '{0, '{255, 255, 255, 255, 255, 255, 255, 255, 0}, 5, 2040},
      '{0, '{1, 2, 3, 4, 5, 6, 7, 8, 0}, 2, 36},
      '{0, '{0, 0, 0, 0, 0, 0, 0, 255, 0}, 7, 255},
      '{1, '{-1, -2, -1, 0, 0, 0, 1, 2, 1}, 9, 0},
      '{1, '{-128, -128, -128, -128, -128, -128, -128, -128, -128}, 15, -1152},
      '{1, '{127, 127, 127, 127, 127, 127, 127, 127, 127}, 1, 1143},
      '{1, '{-128, 127, -1, 1, 5, -5, 100, -100, 3}, 6, 2},
      '{2, '{1, 2, 3, 4, 5, 0, 0, 0, 0}, 171, 15},
      '{2, '{255, 255, 255, 255, 255, 0, 0, 0, 0}, 90, 1275},
      '{2, '{0, 0, 0, 0, 200, 0, 0, 0, 0}, 1, 200},
      '{3, '{167, 0, 0, 0, 0, 0, 0, 0, 0}, 195, 167},
      '{3, '{255, 9, 9, 9, 9, 9, 9, 9, 9}, 255, 255},
      '{1, '{0, 0, 0, 0, 0, 0, 0, 0, -77}, 3, -77}
    };
    for (int s = 0; s < 4; s++) begin
      iv[s] = 1'b0;
      ordy[s] = 1'b1;
      tin[s] = 8'd0;
      for (int i = 0; i < 9; i++) din[s][i] = 8'd0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      check("rst_out_valid", ov[s], 0);
      check("rst_result", res[s], 0);
      check("rst_tag", tg[s], 0);
      check("rst_in_ready", ir[s], 1);
    end
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      apply(vt[i]);
      if (i == 4) check("raw_b80", 32'(ib.result), 32'hB80);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      iv[1] = 1'b1;
      for (int i = 0; i < 9; i++) din[1][i] = 8'(j + 1);
      tin[1] = 8'(j + 1);
    end
    @(negedge clk);
    check("inflight_no_output", ov[1], 0);
    rst = 1'b1;
    iv[1] = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", ov[1], 0);
    check("midrst_result", res[1], 0);
    check("midrst_tag", tg[1], 0);
    check("midrst_in_ready", ir[1], 1);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("flushed_no_output", ov[1], 0);
    end
    apply(vt[5]);
    run(2, 20, 100, 100, -1, 0);
    check("stream_count", pops, 20);
    check("stream_span", last_pop - first_pop + 1, 20);
    run(0, 12, 100, 100, 5, 4);
    run(1, 200, 70, 60, 20, 3);
    run(2, 200, 50, 50, -1, 0);
    run(3, 1000, 50, 50, -1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
